// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates a single-port memory between the 6502 core (c_*) and a
// DMA/test-loader port (d_*). The arbiter grants at most one access per cycle and
// steers read data back one cycle later. Writes into the ROM window are dropped.
// DMA bursts are capped at MAX_BURST consecutive grants while the CPU is waiting.
//
// Ports:
//   ph1, reset                      clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata       CPU request
//   c_rdy, c_rdata, c_rvalid        CPU grant (combinational), read return
//   d_req/d_we/d_addr/d_wdata       DMA request
//   d_gnt, d_rdata, d_rvalid        DMA grant (combinational), read return
//   m_en/m_we/m_addr/m_wdata        memory access (combinational)
//   m_rdata                         memory read data, valid the cycle after a read
//   rom_wr_err                      one-cycle pulse after a dropped ROM write
module mem_bus_arbiter #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE  = ADDR_W'(16'hF000),
    parameter int unsigned       MAX_BURST = 4
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_rdy,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              rom_wr_err
);

    localparam int unsigned STREAK_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    owner_e              rd_owner;
    owner_e              rd_owner_nxt;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
    logic                rom_err_nxt;
    logic                cpu_win;
    logic                dma_win;
    logic                sel_we;
    logic                rom_hit;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Arbitration, memory mux and next-state; grants are suppressed while in reset
    always_comb begin
        cpu_win      = 1'b0;
        dma_win      = 1'b0;
        rd_owner_nxt = OWN_NONE;
        streak_nxt   = '0;

        if (reset) begin
            // DMA has priority until it has used up its burst allowance against a waiting CPU
            if (d_req && !(c_req && (streak == STREAK_MAX))) begin
                dma_win = 1'b1;
            end else if (c_req) begin
                cpu_win = 1'b1;
            end
        end

        sel_addr  = dma_win ? d_addr  : c_addr;
        sel_wdata = dma_win ? d_wdata : c_wdata;
        sel_we    = dma_win ? d_we    : (cpu_win & c_we);
        rom_hit   = (sel_addr >= ROM_BASE);

        m_en    = cpu_win | dma_win;
        m_we    = sel_we & ~rom_hit;
        m_addr  = sel_addr;
        m_wdata = sel_wdata;
        c_rdy   = cpu_win;
        d_gnt   = dma_win;

        rom_err_nxt = sel_we & rom_hit;

        if (dma_win) begin
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
        end

        if (cpu_win && !c_we) begin
            rd_owner_nxt = OWN_CPU;
        end else if (dma_win && !d_we) begin
            rd_owner_nxt = OWN_DMA;
        end

        c_rvalid = (rd_owner == OWN_CPU);
        d_rvalid = (rd_owner == OWN_DMA);
        c_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

    // Read owner, DMA streak and ROM error pulse
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            rd_owner   <= OWN_NONE;
            streak     <= '0;
            rom_wr_err <= 1'b0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            streak     <= streak_nxt;
            rom_wr_err <= rom_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized bench for mem_bus_arbiter. It uses a
// behavioural memory stub plus a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int          MB = 4;
    localparam logic [15:0] ROM = 16'hF000;

    logic          ph1 = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic          c_rdy, c_rvalid, d_gnt, d_rvalid, m_en, m_we, rom_wr_err;
    logic [DW-1:0] c_rdata, d_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;

    always #5 ph1 = ~ph1;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_BASE(ROM), .MAX_BURST(MB)
    ) dut (
        .ph1(ph1), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdy(c_rdy), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .rom_wr_err(rom_wr_err)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Memory stub: unwritten locations hold init_val, reads return one cycle later
    logic [7:0] mem_q  [0:65535];
    bit         mem_wr [0:65535];
    logic [7:0] rd_q;
    always @(posedge ph1) begin
        if (m_en) begin
            rd_q <= mem_wr[m_addr] ? mem_q[m_addr] : init_val(m_addr);
            if (m_we) begin
                mem_q[m_addr]  <= m_wdata;
                mem_wr[m_addr] <= 1'b1;
            end
        end
    end
    assign m_rdata = rd_q;

    // Reference model state
    logic [7:0] ref_mem [0:65535];
    int         dma_run = 0;
    int         pend_owner = 0;
    logic [7:0] pend_data = '0;
    bit         err_pend = 1'b0;
    logic       last_crdy = 1'b0;
    logic       last_dgnt = 1'b0;
    int         passed = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 16'hFFF0 + 16'($urandom_range(0, 15));
        return 16'h0030 + 16'($urandom_range(0, 15));
    endfunction

    // One bus cycle: drive at negedge, check just after, then advance the model
    task automatic cyc(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd);
        int          win;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        we;
        @(negedge ph1);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        if (!dr && !cr)                  win = 0;
        else if (dr && (!cr || dma_run < MB)) win = 2;
        else                             win = 1;
        wa = (win == 2) ? da : ca;
        wd = (win == 2) ? dd : cd;
        we = (win == 2) ? dw : ((win == 1) ? cw : 1'b0);

        check("c_rdy", 32'(c_rdy), 32'(win == 1));
        check("d_gnt", 32'(d_gnt), 32'(win == 2));
        check("m_en", 32'(m_en), 32'(win != 0));
        if (win != 0) begin
            check("m_addr", 32'(m_addr), 32'(wa));
            check("m_we", 32'(m_we), 32'(we && (wa < ROM)));
            if (we) check("m_wdata", 32'(m_wdata), 32'(wd));
        end
        check("c_rvalid", 32'(c_rvalid), 32'(pend_owner == 1));
        check("d_rvalid", 32'(d_rvalid), 32'(pend_owner == 2));
        if (pend_owner == 1) check("c_rdata", 32'(c_rdata), 32'(pend_data));
        if (pend_owner == 2) check("d_rdata", 32'(d_rdata), 32'(pend_data));
        check("rom_wr_err", 32'(rom_wr_err), 32'(err_pend));

        last_crdy = c_rdy;
        last_dgnt = d_gnt;

        err_pend = (win != 0) && we && (wa >= ROM);
        if (win != 0 && !we) begin
            pend_owner = win;
            pend_data  = ref_mem[wa];
        end else begin
            pend_owner = 0;
        end
        if (win != 0 && we && wa < ROM) ref_mem[wa] = wd;
        dma_run = (win == 2) ? ((dma_run < MB) ? dma_run + 1 : dma_run) : 0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_en"},  32'(m_en),  32'(0));
        check({tag, "_m_we"},  32'(m_we),  32'(0));
        check({tag, "_c_rdy"}, 32'(c_rdy), 32'(0));
        check({tag, "_d_gnt"}, 32'(d_gnt), 32'(0));
        check({tag, "_c_rvalid"}, 32'(c_rvalid), 32'(0));
        check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(0));
        check({tag, "_rom_wr_err"}, 32'(rom_wr_err), 32'(0));
    endtask

    initial begin
        logic [9:0] gseq;
        logic [4:0] cseq;
        logic       ch, cw_h;
        logic [15:0] ca_h;
        logic [7:0]  cd_h;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));

        // Reset: requests ignored, all strobes low
        #2;
        c_req = 1'b1; d_req = 1'b1;
        #1;
        check_reset_outputs("in_reset");
        @(negedge ph1);
        c_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;

        // DMA writes 0xCE to 0x0030, CPU reads it on the very next cycle
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0030, 8'hCE);
        cyc(1'b1, 1'b0, 16'h0030, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("cpu_no_wait", 32'(c_rdy), 32'(1));
        idle();
        check("wr_then_rd_data", 32'(c_rdata), 32'h00CE);

        // CPU-only read of 0x0030
        cyc(1'b1, 1'b0, 16'h0030, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("cpu_rd_addr", 32'(m_addr), 32'h0030);
        idle();
        check("cpu_rd_valid", 32'(c_rvalid), 32'(1));
        check("cpu_rd_data", 32'(c_rdata), 32'h00CE);

        // Both reading continuously: D D D D C D D D D C
        gseq = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 16'h0031, 8'h0, 1'b1, 1'b0, 16'(16'h0040 + i), 8'h0);
            gseq = {gseq[8:0], last_dgnt};
        end
        check("grant_seq", 32'(gseq), 32'(10'b1111011110));
        idle();

        // CPU write into ROM is dropped and flagged for one cycle
        cyc(1'b1, 1'b1, 16'hFFFC, 8'h55, 1'b0, 1'b0, 16'h0, 8'h0);
        check("rom_wr_m_we", 32'(m_we), 32'(0));
        idle();
        check("rom_err_rise", 32'(rom_wr_err), 32'(1));
        idle();
        check("rom_err_fall", 32'(rom_wr_err), 32'(0));
        cyc(1'b1, 1'b0, 16'hFFFC, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        idle();
        check("rom_intact", 32'(c_rdata), 32'(init_val(16'hFFFC)));

        // Idle gap clears the streak: D D idle then CPU waits behind 4 DMA grants
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0050, 8'h0);
        cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0051, 8'h0);
        idle();
        cseq = '0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'h0032, 8'h0, 1'b1, 1'b0, 16'(16'h0052 + i), 8'h0);
            cseq = {cseq[3:0], last_crdy};
        end
        check("gap_cpu_seq", 32'(cseq), 32'(5'b00001));
        idle();

        // Reset mid-read with streak at 3
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'(16'h0060 + i), 8'h0);
        @(negedge ph1);
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0033;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0063;
        #1;
        check("pre_rst_dgnt", 32'(d_gnt), 32'(1));
        check("pre_rst_drvalid", 32'(d_rvalid), 32'(1));
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        pend_owner = 0; dma_run = 0; err_pend = 1'b0;
        @(negedge ph1);
        #1;
        check_reset_outputs("rst_after_edge");
        c_req = 1'b0; d_req = 1'b0;
        reset = 1'b1;
        cseq = '0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'h0034, 8'h0, 1'b1, 1'b0, 16'(16'h0070 + i), 8'h0);
            cseq = {cseq[3:0], last_crdy};
        end
        check("post_rst_cpu_seq", 32'(cseq), 32'(5'b00001));

        // Randomized traffic; the CPU holds its request until granted
        ch = 1'b0; cw_h = 1'b0; ca_h = '0; cd_h = '0;
        for (int i = 0; i < 400; i++) begin
            if (!ch && $urandom_range(0, 1) == 1) begin
                ch   = 1'b1;
                cw_h = 1'($urandom_range(0, 1));
                ca_h = rnd_addr();
                cd_h = 8'($urandom);
            end
            cyc(ch, cw_h, ca_h, cd_h,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
            if (last_crdy) ch = 1'b0;
        end
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory arbiter between the 6502 core and a DMA/test-loader port, sitting in `top` directly in front of `mem`. It grants at most one access per cycle and routes write data and addresses to memory. It steers read data back to the correct requester one cycle later and stalls the CPU via `c_rdy`. It also drops writes into the ROM window and enforces a CPU anti-starvation limit on DMA bursts.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `ROM_BASE`, 16'hF000, first ROM address; ROM spans `ROM_BASE`..all-ones
- `MAX_BURST`, 4, maximum consecutive DMA grants while the CPU is waiting (≥1)

Ports:
- `ph1`  in  1  clock; the only clock, all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `c_req`  in  1  CPU access request
- `c_we`  in  1  CPU write enable
- `c_addr`  in  ADDR_W  CPU address
- `c_wdata`  in  DATA_W  CPU write data
- `c_rdy`  out  1  CPU granted this cycle; CPU holds request while 0
- `c_rdata`  out  DATA_W  CPU read data
- `c_rvalid`  out  1  `c_rdata` valid
- `d_req`, `d_we`, `d_addr`, `d_wdata`  in  1/1/ADDR_W/DATA_W  DMA request, same meaning as the CPU signals
- `d_gnt`  out  1  DMA granted this cycle
- `d_rdata`  out  DATA_W  DMA read data
- `d_rvalid`  out  1  `d_rdata` valid
- `m_en`  out  1  memory access strobe
- `m_we`  out  1  memory write
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data; valid the cycle after the `m_en` read
- `rom_wr_err`  out  1  one-cycle pulse: a write to ROM was dropped

## Operation
- Registered state:
  - `rd_owner`: NONE, CPU or DMA. It records who issued a read last cycle.
  - `streak`: 0..MAX_BURST, counts consecutive DMA grants.
  - `rom_wr_err` register.
- Arbitration each cycle, combinational from current inputs and state:
  - Only `d_req` asserted: the DMA is granted.
  - Only `c_req` asserted: the CPU is granted.
  - Both asserted: the DMA wins, unless `streak == MAX_BURST`, in which case the CPU wins.
  - Neither asserted: no grant, and `m_en = 0`.
- Grant effects:
  - `m_en = 1`.
  - `m_addr` and `m_wdata` are muxed from the winner.
  - `c_rdy` or `d_gnt` is high for the winner only. The loser's signal stays 0 and the loser keeps its request asserted.
- ROM protect: for a granted write with `addr >= ROM_BASE`:
  - `m_we` is forced to 0 and the grant still completes.
  - `rom_wr_err` goes to 1 next cycle for exactly one cycle.
- `streak` update:
  - DMA grant: +1, saturating at MAX_BURST.
  - CPU grant or idle cycle: cleared to 0.
- `rd_owner` update: set to the winner on a granted read, otherwise NONE.
- Read return:
  - `c_rvalid = (rd_owner == CPU)` and `d_rvalid = (rd_owner == DMA)`.
  - Both `c_rdata` and `d_rdata` are driven from `m_rdata` at all times.
  - Consumers qualify the data with their rvalid.
- While `reset` is asserted:
  - Requests are ignored.
  - `m_en`, `m_we`, `c_rdy`, `d_gnt`, `c_rvalid`, `d_rvalid` and `rom_wr_err` are all 0.
  - `m_addr`, `m_wdata`, `c_rdata` and `d_rdata` carry don't-care values.

## Timing
- Reset is asynchronous:
  - Asserting `reset` immediately clears `rd_owner` to NONE, `streak` to 0 and `rom_wr_err` to 0.
  - A read in flight at reset produces no rvalid.
- Grant latency is 0 cycles. In cycle N, `req` and `gnt` are high combinationally and the access is accepted at the end of cycle N.
- Read data latency is 1 cycle. Read issued in cycle N → rvalid and data in cycle N+1.
- Back-to-back reads are allowed every cycle, and read return and new issue overlap.
- A write followed by a read of the same address in the next cycle returns the new data, because memory updates at the end of the write cycle.
- `rom_wr_err` rises in cycle N+1 for a dropped write in cycle N.
- Worst-case CPU wait under continuous DMA is MAX_BURST cycles.
- Request inputs must be stable before the `ph1` rising edge. Outputs are not registered, except rvalid and `rom_wr_err`.

## Test plan
- CPU only, read 0x0030, memory holds 0xCE:
  - Cycle N: `c_rdy=1`, `m_en=1`, `m_addr=0x0030`, `m_we=0`.
  - Cycle N+1: `c_rvalid=1`, `c_rdata=0xCE`, `d_rvalid=0`.
- Both requesters continuously reading, MAX_BURST=4:
  - Grant sequence is D D D D C D D D D C.
  - Every rvalid lands on the correct port one cycle after its grant.
- DMA writes 0xCE to 0x0030, then the CPU reads 0x0030 in the next cycle:
  - The CPU waits exactly 0 extra cycles after the DMA drops its request.
  - `c_rdata=0xCE`.
- CPU writes 0x55 to 0xFFFC:
  - `c_rdy=1`, `m_en=1`, `m_we=0`.
  - Next cycle `rom_wr_err=1` for exactly one cycle.
  - A later read of 0xFFFC still returns the original ROM value.
- Idle gap clears the streak:
  - Sequence D D (idle) D D D D with the CPU requesting from the gap on.
  - The CPU is granted only after the 4th post-gap DMA grant.
- Reset asserted mid-read with `streak=3`:
  - All outputs listed in Operation go to 0 immediately, and no rvalid follows.
  - After release, with both requesting, the DMA gets 4 grants before the CPU.
